csr_trap_seq: RTL and testbench
===============================

// Module: csr_trap_seq
// PURPOSE
//  Trap/return sequencer and write-port arbiter for the machine-mode CSR file.
//  Takes exceptions/interrupts (trap) and MRET from the pipeline and drives the
//  CSR file's single write port for mepc, mcause, mtval and mstatus, one register per cycle.
//  Issues the fetch redirect and the pipeline invalidate. Grants ordinary CSR instruction
//  accesses only when no trap/return sequence is pending or running.
// PARAMETERS
//  XLEN  32  datapath width (RV32 only)
// PORTS
//  clk             in   1     clock
//  rst             in   1     reset; asynchronous, active-high
//  trap_valid      in   1     trap request; holds cause/pc/tval stable until trap_ready
//  trap_ready      out  1     trap accepted this cycle
//  trap_cause      in   XLEN  mcause value (bit XLEN-1 = interrupt)
//  trap_pc         in   XLEN  faulting/interrupted PC -> mepc
//  trap_tval       in   XLEN  -> mtval
//  mret_valid      in   1     MRET retire request
//  mret_ready      out  1     MRET accepted this cycle
//  csrreq_valid    in   1     CSR instruction wants the CSR file
//  csrreq_ready    out  1     grant to CSR instruction (same cycle)
//  mstatus         in   XLEN  current mstatus from CSR file
//  mtvec           in   XLEN  current mtvec from CSR file
//  mepc            in   XLEN  current mepc from CSR file
//  csr_we          out  1     write strobe to CSR file
//  csr_addr        out  12    CSR address (0x341 mepc, 0x342 mcause, 0x343 mtval, 0x300 mstatus)
//  csr_wdata       out  XLEN  write data
//  redirect_valid  out  1     one-cycle fetch redirect pulse
//  redirect_pc     out  XLEN  redirect target
//  invalidate      out  1     pipeline flush pulse, coincident with redirect_valid
//  busy            out  1     sequence in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; latched cause/pc/tval cleared.
//  - States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, R_MSTATUS, REDIRECT.
//  - IDLE priority: trap > mret > csrreq. Accepts at most one per cycle.
//    trap_valid: trap_ready=1, latch cause/pc/tval, -> T_MEPC.
//    else mret_valid: mret_ready=1, latch target=mepc, -> R_MSTATUS.
//    else csrreq_ready=csrreq_valid. csrreq_ready=0 in every non-IDLE state
//    and in IDLE whenever trap_valid or mret_valid is high.
//  - T_MEPC: we=1, addr 0x341, wdata={pc[XLEN-1:2],2'b00} -> T_MCAUSE.
//  - T_MCAUSE: we=1, 0x342, cause -> T_MTVAL.
//  - T_MTVAL: we=1, 0x343, tval -> T_MSTATUS.
//  - T_MSTATUS: we=1, 0x300, mstatus with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11;
//    other bits unchanged. Latch target=trap vector. -> REDIRECT.
//  - R_MSTATUS: we=1, 0x300, mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b11 -> REDIRECT.
//  - REDIRECT: redirect_valid=1, invalidate=1, redirect_pc=target -> IDLE.
//  - Latency: trap acceptance to redirect = 5 cycles; MRET acceptance to redirect = 2 cycles.
//  - csr_we/addr/wdata are registered from state; csr_we=0 and addr/wdata=0 in IDLE/REDIRECT.
//  - trap_valid/mret_valid during a sequence are ignored (ready=0); requester holds.
//  - Trap vector base = {mtvec[XLEN-1:2],2'b00}; sum arithmetic mod 2^XLEN (wraps).
//  - Simultaneous trap and mret in IDLE: trap wins; mret_ready=0.
//  - rst mid-sequence: returns to IDLE immediately; partial CSR writes are not undone.
// CONFIGURATION
//  CSR_TRAP_VECTORED_EN defined: if mtvec[1:0]==2'b01 and cause[XLEN-1]==1,
//    target = base + (cause[XLEN-2:0] << 2); otherwise target = base.
//  Not defined: target = base for all traps; mtvec mode bits ignored.
// TESTING
//  1 Reset mid-T_MCAUSE (assert rst async) -> busy, csr_we, redirect_valid 0 before next clk edge.
//  2 Trap with cause=2, pc=0x0000_1006, tval=0xDEAD_BEEF, mtvec=0x8000_0000, mstatus=0x8
//    -> writes 0x341=0x1004, 0x342=2, 0x343=0xDEADBEEF, 0x300=0x1880 on consecutive
//    cycles; redirect_pc=0x8000_0000 5 cycles after trap_ready.
//  3 MRET with mepc=0x400, mstatus=0x1880 -> 0x300 written 0x1888; redirect 0x400 2 cycles
//    after mret_ready.
//  4 trap_valid, mret_valid, csrreq_valid all high in IDLE -> only trap_ready=1; csrreq
//    granted the cycle after REDIRECT while still held high.
//  5 Vectored: mtvec=0x8000_0001, cause=0x8000_0007 -> redirect_pc=0x8000_001C with
//    CSR_TRAP_VECTORED_EN defined, 0x8000_0000 without.
//  6 Wrap: mtvec=0xFFFF_FFF1, cause=0x8000_0007, vectored -> redirect_pc=0x0000_000C.

Source files
------------

// File: rtl/csr_trap_seq.sv
// Trap/MRET sequencer and write-port arbiter for the machine-mode CSR file.
// Optional build macro: CSR_TRAP_VECTORED_EN (vectored interrupt targets when mtvec mode is 01).
module csr_trap_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  output logic            mret_ready,
  input  logic            csrreq_valid,
  output logic            csrreq_ready,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            invalidate,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, R_MSTATUS, REDIRECT
  } state_t;

  state_t state, next_state;

  logic [XLEN-1:0] cause_q, pc_q, tval_q, target_q;
  logic [XLEN-1:0] base, vector, trap_mstatus, ret_mstatus;

  // Masking rather than slicing keeps every mtvec bit referenced in both builds.
  assign base = mtvec & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef CSR_TRAP_VECTORED_EN
  always_comb begin
    vector = base;
    if (mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
      vector = base + ({1'b0, cause_q[XLEN-2:0]} << 2);
  end
`else
  assign vector = base;
`endif

  always_comb begin
    trap_mstatus        = mstatus;
    trap_mstatus[7]     = mstatus[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    ret_mstatus         = mstatus;
    ret_mstatus[3]      = mstatus[7];
    ret_mstatus[7]      = 1'b1;
    ret_mstatus[12:11]  = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && trap_valid) begin
        cause_q <= trap_cause;
        pc_q    <= trap_pc;
        tval_q  <= trap_tval;
      end else if (state == IDLE && mret_valid) begin
        target_q <= mepc;
      end else if (state == T_MSTATUS) begin
        target_q <= vector;
      end
    end
  end

  // Write-port and redirect outputs decode purely from the registered state.
  always_comb begin
    next_state     = state;
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    csrreq_ready   = 1'b0;
    csr_we         = 1'b0;
    csr_addr       = 12'h000;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    invalidate     = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (trap_valid) begin
          trap_ready = 1'b1;
          next_state = T_MEPC;
        end else if (mret_valid) begin
          mret_ready = 1'b1;
          next_state = R_MSTATUS;
        end else begin
          csrreq_ready = csrreq_valid;
        end
      end
      T_MEPC: begin
        csr_we     = 1'b1;
        csr_addr   = 12'h341;
        csr_wdata  = {pc_q[XLEN-1:2], 2'b00};
        next_state = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_we     = 1'b1;
        csr_addr   = 12'h342;
        csr_wdata  = cause_q;
        next_state = T_MTVAL;
      end
      T_MTVAL: begin
        csr_we     = 1'b1;
        csr_addr   = 12'h343;
        csr_wdata  = tval_q;
        next_state = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr   = 12'h300;
        csr_wdata  = trap_mstatus;
        next_state = REDIRECT;
      end
      R_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr   = 12'h300;
        csr_wdata  = ret_mstatus;
        next_state = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        invalidate     = 1'b1;
        redirect_pc    = target_q;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed self-checking bench for csr_trap_seq; expectations follow CSR_TRAP_VECTORED_EN if defined.
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, trap_ready, mret_valid, mret_ready;
  logic        csrreq_valid, csrreq_ready;
  logic [31:0] trap_cause, trap_pc, trap_tval, mstatus, mtvec, mepc;
  logic        csr_we, redirect_valid, invalidate, busy;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, redirect_pc;

  int tests = 0;
  int fails = 0;

  csr_trap_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .csrreq_valid(csrreq_valid), .csrreq_ready(csrreq_ready),
    .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .invalidate(invalidate), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic tv, input logic mv, input logic cv);
    trap_valid   = tv;
    mret_valid   = mv;
    csrreq_valid = cv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [11:0] addr, input logic [31:0] data);
    checkOutput({tag, "_we"}, {31'b0, csr_we}, 32'd1);
    checkOutput({tag, "_addr"}, {20'b0, csr_addr}, {20'b0, addr});
    checkOutput({tag, "_wdata"}, csr_wdata, data);
  endtask

  task automatic checkRedirect(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_rv"}, {31'b0, redirect_valid}, 32'd1);
    checkOutput({tag, "_inv"}, {31'b0, invalidate}, 32'd1);
    checkOutput({tag, "_pc"}, redirect_pc, pc);
    checkOutput({tag, "_we0"}, {31'b0, csr_we}, 32'd0);
  endtask

  // Accepts a trap in IDLE, then walks the four writes to the redirect cycle.
  task automatic runTrap(input string tag, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic [31:0] mst_exp,
                         input logic [31:0] target);
    trap_cause = cause;
    trap_pc    = pc;
    trap_tval  = tval;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_trap_ready"}, {31'b0, trap_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWrite({tag, "_mepc"}, 12'h341, {pc[31:2], 2'b00});
    tick();
    checkWrite({tag, "_mcause"}, 12'h342, cause);
    tick();
    checkWrite({tag, "_mtval"}, 12'h343, tval);
    tick();
    checkWrite({tag, "_mstatus"}, 12'h300, mst_exp);
    tick();
    checkRedirect({tag, "_redir"}, target);
    tick();
    checkOutput({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mstatus = 32'h0000_0008; mtvec = 32'h8000_0000; mepc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_we", {31'b0, csr_we}, 32'd0);
    checkOutput("rst_rv", {31'b0, redirect_valid}, 32'd0);
    checkOutput("rst_addr", {20'b0, csr_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // Plain CSR grant in IDLE
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("csr_grant", {31'b0, csrreq_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // Basic trap sequence
    runTrap("trap", 32'd2, 32'h0000_1006, 32'hDEAD_BEEF, 32'h0000_1880, 32'h8000_0000);

    // MRET sequence
    mstatus = 32'h0000_1880;
    mepc    = 32'h0000_0400;
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("mret_ready", {31'b0, mret_ready}, 32'd1);
    checkOutput("mret_csr0", {31'b0, csrreq_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWrite("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();
    checkRedirect("mret_redir", 32'h0000_0400);
    tick();
    checkOutput("mret_idle", {31'b0, busy}, 32'd0);

    // All three requests at once: trap wins, CSR waits until after redirect
    mstatus = 32'h0000_0008;
    trap_cause = 32'd5; trap_pc = 32'h0000_2000; trap_tval = 32'h0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("prio_trap", {31'b0, trap_ready}, 32'd1);
    checkOutput("prio_mret", {31'b0, mret_ready}, 32'd0);
    checkOutput("prio_csr", {31'b0, csrreq_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("busy_mret_ign", {31'b0, mret_ready}, 32'd0);
    checkOutput("busy_csr_ign", {31'b0, csrreq_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("prio_csr_blk", {31'b0, csrreq_ready}, 32'd0);
    tick();
    checkRedirect("prio_redir", 32'h8000_0000);
    checkOutput("prio_csr_redir", {31'b0, csrreq_ready}, 32'd0);
    tick();
    checkOutput("prio_csr_after", {31'b0, csrreq_ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // Vectored interrupt and wrap-around target
    mtvec = 32'h8000_0001;
`ifdef CSR_TRAP_VECTORED_EN
    runTrap("vec", 32'h8000_0007, 32'h0000_3000, 32'h0, 32'h0000_1880, 32'h8000_001C);
`else
    runTrap("vec", 32'h8000_0007, 32'h0000_3000, 32'h0, 32'h0000_1880, 32'h8000_0000);
`endif
    mtvec = 32'hFFFF_FFF1;
`ifdef CSR_TRAP_VECTORED_EN
    runTrap("wrap", 32'h8000_0007, 32'h0000_3004, 32'h0, 32'h0000_1880, 32'h0000_000C);
`else
    runTrap("wrap", 32'h8000_0007, 32'h0000_3004, 32'h0, 32'h0000_1880, 32'hFFFF_FFF0);
`endif

    // Asynchronous reset in the middle of T_MCAUSE
    mtvec = 32'h8000_0000;
    trap_cause = 32'd3; trap_pc = 32'h0000_4000; trap_tval = 32'h1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("mid_addr", {20'b0, csr_addr}, 32'h0000_0342);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_we", {31'b0, csr_we}, 32'd0);
    checkOutput("arst_rv", {31'b0, redirect_valid}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("arst_idle", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
